i2c_monitor_fifo: RTL and testbench

- Passive I2C bus monitor, successor to the fixed single-mode monitor.
- Debounces the raw SDA/SCL GPIO pins and decodes START, repeated START, data bytes, ACK/NACK, STOP and SCL-stuck timeout.
- Decoded events are pushed as 8-bit tokens into a parametrised FIFO with a valid/ready drain port.
- Sits between the GPIO pins and the UART/host logging path. Debounce, FIFO depth, timeout and restart encoding are parameters.

---
 rtl/i2c_mon_pkg.sv | 26 ++
 rtl/i2c_debounce.sv | 53 +++++
 rtl/i2c_monitor_fifo.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_monitor_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_mon_pkg
// Description : Shared token codes and decoder state encoding for the
//               passive I2C bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_mon_pkg;

    // Control tokens placed in the event stream (out_is_data = 0)
    localparam logic [7:0] TOK_START   = 8'h53;
    localparam logic [7:0] TOK_RESTART = 8'h52;
    localparam logic [7:0] TOK_ACK     = 8'h41;
    localparam logic [7:0] TOK_NACK    = 8'h4E;
    localparam logic [7:0] TOK_STOP    = 8'h80;
    localparam logic [7:0] TOK_TIMEOUT = 8'h54;

    // Decoder states: bus idle, shifting data bits, waiting for the ACK bit
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        ACKB = 2'd2
    } mon_state_t;

endpackage : i2c_mon_pkg
`default_nettype wire

// File: rtl/i2c_debounce.sv
`default_nettype none
// ============================================================================
// Module      : i2c_debounce
// Description : Two-flop synchronizer followed by a persistence filter for
//               one raw GPIO pin. The filtered level follows the pin only
//               after the synchronized value has differed from it for
//               DEBOUNCE_CYCLES consecutive clocks (pin-to-level latency is
//               2 + DEBOUNCE_CYCLES clocks).
// Ports       : clk   - system clock
//               rst   - synchronous active-low reset (level resets to 1)
//               pin   - raw asynchronous pin
//               level - debounced, synchronous level
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_debounce #(
    parameter int DEBOUNCE_CYCLES = 75
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level
);

    localparam int            CW       = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], pin};
            // Any return to agreement restarts the persistence window
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;

endmodule : i2c_debounce
`default_nettype wire

// File: rtl/i2c_monitor_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_monitor_fifo
// Description : Passive I2C bus monitor. Debounces SDA/SCL, decodes START,
//               repeated START, data bytes, ACK/NACK, STOP and SCL-stuck
//               timeout, and queues 8-bit event tokens in a FIFO drained
//               through a valid/ready port.
// Ports       : clk, rst (sync, active-low)
//               SDA_GPIO, SCL_GPIO        - raw bus pins
//               out_data/out_is_data      - FIFO head token and its kind
//               out_valid/out_ready       - drain handshake
//               fifo_level                - occupancy 0..FIFO_DEPTH
//               overflow/drop_cnt         - sticky drop flag, drop counter
//               bus_active                - transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_monitor_fifo
    import i2c_mon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 75,
    parameter int FIFO_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES  = 20000,
    parameter int RESTART_TOKEN   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SDA_GPIO,
    input  logic                        SCL_GPIO,
    output logic [7:0]                  out_data,
    output logic                        out_is_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic [15:0]                 drop_cnt,
    output logic                        bus_active
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            LW      = AW + 1;
    localparam int            TW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [7:0]    RS_TOK  = (RESTART_TOKEN != 0) ? TOK_RESTART : TOK_START;

    // ------------------------------------------------------------------
    // Input conditioning and edge detection
    // ------------------------------------------------------------------
    logic w_sda;
    logic w_scl;
    logic r_sda_d;
    logic r_scl_d;

    i2c_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sda (
        .clk   (clk),
        .rst   (rst),
        .pin   (SDA_GPIO),
        .level (w_sda)
    );

    i2c_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_scl (
        .clk   (clk),
        .rst   (rst),
        .pin   (SCL_GPIO),
        .level (w_scl)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sda_d <= 1'b1;
            r_scl_d <= 1'b1;
        end else begin
            r_sda_d <= w_sda;
            r_scl_d <= w_scl;
        end
    end

    logic w_start;
    logic w_stop;
    logic w_scl_rise;

    assign w_start    =  r_sda_d & ~w_sda & w_scl;
    assign w_stop     = ~r_sda_d &  w_sda & w_scl;
    assign w_scl_rise = ~r_scl_d &  w_scl;

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    mon_state_t    r_state;
    mon_state_t    w_state_nx;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    w_bit_cnt_nx;
    logic [6:0]    r_shreg;
    logic [6:0]    w_shreg_nx;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;
    logic          w_push;
    logic [8:0]    w_push_word;

    // Counts consecutive SCL-low clocks only while a transfer is open
    always_ff @(posedge clk) begin
        if (!rst || r_state == IDLE || w_scl) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state != IDLE) && !w_scl
                       && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shreg   <= 7'd0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shreg   <= w_shreg_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shreg_nx   = r_shreg;
        w_push       = 1'b0;
        w_push_word  = 9'd0;
        case (r_state)
            IDLE: begin
                // A STOP seen here is deliberately ignored
                if (w_start) begin
                    w_push       = 1'b1;
                    w_push_word  = {1'b0, TOK_START};
                    w_state_nx   = BITS;
                    w_bit_cnt_nx = 3'd0;
                end
            end
            BITS, ACKB: begin
                // START/STOP happen with SCL high, timeout with SCL low, so
                // they never coincide; START/STOP win over a same-cycle SCL rise.
                if (w_start) begin
                    w_push       = 1'b1;
                    w_push_word  = {1'b0, RS_TOK};
                    w_state_nx   = BITS;
                    w_bit_cnt_nx = 3'd0;
                end else if (w_stop) begin
                    w_push      = 1'b1;
                    w_push_word = {1'b0, TOK_STOP};
                    w_state_nx  = IDLE;
                end else if (w_timeout) begin
                    w_push      = 1'b1;
                    w_push_word = {1'b0, TOK_TIMEOUT};
                    w_state_nx  = IDLE;
                end else if (w_scl_rise) begin
                    if (r_state == BITS) begin
                        w_shreg_nx = {r_shreg[5:0], w_sda};
                        if (r_bit_cnt == 3'd7) begin
                            w_push       = 1'b1;
                            w_push_word  = {1'b1, r_shreg, w_sda};
                            w_state_nx   = ACKB;
                            w_bit_cnt_nx = 3'd0;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_push       = 1'b1;
                        w_push_word  = {1'b0, (w_sda ? TOK_NACK : TOK_ACK)};
                        w_state_nx   = BITS;
                        w_bit_cnt_nx = 3'd0;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign bus_active = (r_state != IDLE);

    // ------------------------------------------------------------------
    // Token FIFO, entries are {is_data, data}
    // ------------------------------------------------------------------
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;

    assign w_pop  = (r_count != '0) & out_ready;
    assign w_full = (r_count == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    // Head is forced to zero when empty so the outputs are clean after reset
    assign out_valid   = (r_count != '0);
    assign out_data    = out_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
    assign out_is_data = out_valid ? r_mem[r_rd_ptr][8]   : 1'b0;
    assign fifo_level  = r_count;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule : i2c_monitor_fifo
`default_nettype wire

// File: tb/tb_i2c_monitor_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_monitor_fifo
// Description : Directed bench for the I2C monitor. Two instances watch the
//               same bus: dut0 (depth 16, legacy restart token) and dut1
//               (depth 4, TOK_RESTART), both with a 1000-clock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_monitor_fifo;

    localparam int HOLD = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sda_pin, scl_pin, ready0, ready1;

    logic [7:0]  d0_data, d1_data;
    logic        d0_is_data, d1_is_data, d0_valid, d1_valid;
    logic [4:0]  d0_level;
    logic [2:0]  d1_level;
    logic        d0_ovf, d1_ovf, d0_busy, d1_busy;
    logic [15:0] d0_drop, d1_drop;

    int vec = 0;
    int err = 0;
    bit bounce = 1'b0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    i2c_monitor_fifo #(
        .DEBOUNCE_CYCLES(75), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(1000), .RESTART_TOKEN(0)
    ) dut0 (
        .clk(clk), .rst(rst), .SDA_GPIO(sda_pin), .SCL_GPIO(scl_pin),
        .out_data(d0_data), .out_is_data(d0_is_data), .out_valid(d0_valid),
        .out_ready(ready0), .fifo_level(d0_level), .overflow(d0_ovf),
        .drop_cnt(d0_drop), .bus_active(d0_busy)
    );

    i2c_monitor_fifo #(
        .DEBOUNCE_CYCLES(75), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1000), .RESTART_TOKEN(1)
    ) dut1 (
        .clk(clk), .rst(rst), .SDA_GPIO(sda_pin), .SCL_GPIO(scl_pin),
        .out_data(d1_data), .out_is_data(d1_is_data), .out_valid(d1_valid),
        .out_ready(ready1), .fifo_level(d1_level), .overflow(d1_ovf),
        .drop_cnt(d1_drop), .bus_active(d1_busy)
    );

    // Record every accepted token
    always @(negedge clk) begin
        if (rst === 1'b1 && d0_valid === 1'b1 && ready0 === 1'b1) q0.push_back({d0_is_data, d0_data});
        if (rst === 1'b1 && d1_valid === 1'b1 && ready1 === 1'b1) q1.push_back({d1_is_data, d1_data});
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setp(input bit is_sda, input logic v);
        if (is_sda) sda_pin = v;
        else        scl_pin = v;
    endtask

    // Drive one pin level, optionally preceded by sub-threshold bounce pulses
    task automatic drive(input bit is_sda, input logic v);
        if (bounce) begin
            for (int k = 0; k < 2; k++) begin
                setp(is_sda, v);
                wait_clk(30);
                setp(is_sda, ~v);
                wait_clk(20);
            end
        end
        setp(is_sda, v);
        wait_clk(HOLD);
    endtask

    task automatic bus_start();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic bus_restart();
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic bus_stop();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, b);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; sda_pin = 1'b1; scl_pin = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        wait_clk(4);
        vec++;
        if ({d0_valid, d0_is_data, d0_data, d0_level, d0_ovf, d0_drop, d0_busy} !== 33'd0) begin
            err++;
            $display("FAIL reset_dut0 got v=%b d=%h lvl=%0d ovf=%b drop=%0d busy=%b want all 0",
                     d0_valid, d0_data, d0_level, d0_ovf, d0_drop, d0_busy);
        end
        vec++;
        if ({d1_valid, d1_is_data, d1_data, d1_level, d1_ovf, d1_drop, d1_busy} !== 31'd0) begin
            err++;
            $display("FAIL reset_dut1 got v=%b d=%h lvl=%0d ovf=%b drop=%0d busy=%b want all 0",
                     d1_valid, d1_data, d1_level, d1_ovf, d1_drop, d1_busy);
        end
        rst = 1'b1;
        wait_clk(200);
        vec++;
        if ({d0_valid, d0_level, d0_busy, d1_valid, d1_level, d1_busy} !== 12'd0) begin
            err++;
            $display("FAIL post_reset_idle got v0=%b l0=%0d b0=%b v1=%b l1=%0d b1=%b want 0",
                     d0_valid, d0_level, d0_busy, d1_valid, d1_level, d1_busy);
        end
    endtask

    // Bouncing message 1 into dut0 (draining) and dut1 (stalled, depth 4)
    task automatic test_message1();
        logic [8:0] exp [6];
        exp = '{9'h053, 9'h1AB, 9'h041, 9'h169, 9'h041, 9'h080};
        q0.delete(); q1.delete();
        bounce = 1'b1; ready0 = 1'b1; ready1 = 1'b0;
        bus_start();
        vec++;
        if (d0_busy !== 1'b1) begin
            err++; $display("FAIL msg1_busy_after_start got %b want 1", d0_busy);
        end
        send_byte(8'hAB); send_bit(1'b0);
        send_byte(8'h69); send_bit(1'b0);
        bus_stop();
        bounce = 1'b0;
        vec++;
        if (d0_busy !== 1'b0) begin
            err++; $display("FAIL msg1_busy_after_stop got %b want 0", d0_busy);
        end
        vec++;
        if (q0.size() != 6) begin
            err++; $display("FAIL msg1_count_dut0 got %0d want 6", q0.size());
        end
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (q0.size() <= i || q0[i] !== exp[i]) begin
                err++;
                $display("FAIL msg1_tok%0d_dut0 got %h want %h", i,
                         (q0.size() > i) ? q0[i] : 9'h1FF, exp[i]);
            end
        end
        vec++;
        if (d1_level !== 3'd4 || d1_ovf !== 1'b1 || d1_drop !== 16'd2) begin
            err++;
            $display("FAIL overflow_dut1 got lvl=%0d ovf=%b drop=%0d want 4 1 2",
                     d1_level, d1_ovf, d1_drop);
        end
        vec++;
        if ({d1_valid, d1_is_data, d1_data} !== 10'h253) begin
            err++;
            $display("FAIL stalled_head_dut1 got v=%b isd=%b d=%h want 1 0 53",
                     d1_valid, d1_is_data, d1_data);
        end
        ready1 = 1'b1;
        wait_clk(20);
        vec++;
        if (q1.size() != 4 || d1_level !== 3'd0) begin
            err++; $display("FAIL drain_dut1 got cnt=%0d lvl=%0d want 4 0", q1.size(), d1_level);
        end
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (q1.size() <= i || q1[i] !== exp[i]) begin
                err++;
                $display("FAIL drain_tok%0d_dut1 got %h want %h", i,
                         (q1.size() > i) ? q1[i] : 9'h1FF, exp[i]);
            end
        end
    endtask

    task automatic test_glitch();
        q0.delete(); q1.delete();
        sda_pin = 1'b0;
        wait_clk(40);
        sda_pin = 1'b1;
        wait_clk(300);
        vec++;
        if (q0.size() != 0 || q1.size() != 0 || d0_busy !== 1'b0 || d1_busy !== 1'b0
            || d0_level !== 5'd0) begin
            err++;
            $display("FAIL glitch got tok0=%0d tok1=%0d busy0=%b busy1=%b want 0 0 0 0",
                     q0.size(), q1.size(), d0_busy, d1_busy);
        end
    endtask

    task automatic test_restart();
        logic [8:0] exp [11];
        exp = '{9'h053, 9'h108, 9'h041, 9'h053, 9'h188, 9'h041,
                9'h106, 9'h041, 9'h100, 9'h04E, 9'h080};
        q0.delete(); q1.delete();
        bus_start();
        send_byte(8'h08); send_bit(1'b0);
        bus_restart();
        send_byte(8'h88); send_bit(1'b0);
        send_byte(8'h06); send_bit(1'b0);
        send_byte(8'h00); send_bit(1'b1);
        bus_stop();
        vec++;
        if (q0.size() != 11 || q1.size() != 11) begin
            err++; $display("FAIL restart_count got %0d/%0d want 11", q0.size(), q1.size());
        end
        for (int i = 0; i < 11; i++) begin
            vec++;
            if (q0.size() <= i || q0[i] !== exp[i]) begin
                err++;
                $display("FAIL restart_tok%0d_dut0 got %h want %h", i,
                         (q0.size() > i) ? q0[i] : 9'h1FF, exp[i]);
            end
        end
        exp[3] = 9'h052;
        for (int i = 0; i < 11; i++) begin
            vec++;
            if (q1.size() <= i || q1[i] !== exp[i]) begin
                err++;
                $display("FAIL restart_tok%0d_dut1 got %h want %h", i,
                         (q1.size() > i) ? q1[i] : 9'h1FF, exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        q0.delete(); q1.delete();
        bus_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_clk(1200);
        vec++;
        if (q0.size() != 2 || q0[0] !== 9'h053 || q0[1] !== 9'h054) begin
            err++;
            $display("FAIL timeout_dut0 got cnt=%0d t0=%h t1=%h want 2 053 054",
                     q0.size(), q0[0], q0[1]);
        end
        vec++;
        if (q1.size() != 2 || q1[0] !== 9'h053 || q1[1] !== 9'h054) begin
            err++;
            $display("FAIL timeout_dut1 got cnt=%0d t0=%h t1=%h want 2 053 054",
                     q1.size(), q1[0], q1[1]);
        end
        vec++;
        if (d0_busy !== 1'b0 || d1_busy !== 1'b0) begin
            err++; $display("FAIL timeout_busy got %b/%b want 0", d0_busy, d1_busy);
        end
        // STOP condition while idle must produce nothing
        bus_stop();
        vec++;
        if (q0.size() != 2 || d0_busy !== 1'b0) begin
            err++; $display("FAIL idle_stop got cnt=%0d busy=%b want 2 0", q0.size(), d0_busy);
        end
    endtask

    task automatic test_reset_mid();
        q0.delete(); q1.delete();
        ready0 = 1'b0; ready1 = 1'b0;
        bus_start();
        send_byte(8'hAB); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        vec++;
        if (d0_level !== 5'd3 || d0_busy !== 1'b1) begin
            err++; $display("FAIL premid_dut0 got lvl=%0d busy=%b want 3 1", d0_level, d0_busy);
        end
        vec++;
        if (d1_ovf !== 1'b1 || d1_drop !== 16'd2) begin
            err++; $display("FAIL sticky_dut1 got ovf=%b drop=%0d want 1 2", d1_ovf, d1_drop);
        end
        rst = 1'b0;
        wait_clk(1);
        vec++;
        if (d0_level !== 5'd0 || d0_valid !== 1'b0 || d0_busy !== 1'b0) begin
            err++;
            $display("FAIL midreset_dut0 got lvl=%0d v=%b busy=%b want 0 0 0",
                     d0_level, d0_valid, d0_busy);
        end
        vec++;
        if (d1_level !== 3'd0 || d1_valid !== 1'b0 || d1_ovf !== 1'b0 || d1_drop !== 16'd0) begin
            err++;
            $display("FAIL midreset_dut1 got lvl=%0d v=%b ovf=%b drop=%0d want 0 0 0 0",
                     d1_level, d1_valid, d1_ovf, d1_drop);
        end
        rst = 1'b1;
        wait_clk(HOLD);
        drive(1'b0, 1'b1);
        wait_clk(HOLD);
        vec++;
        if (d0_level !== 5'd0 || d0_busy !== 1'b0 || d1_level !== 3'd0) begin
            err++;
            $display("FAIL after_midreset got lvl0=%0d busy0=%b lvl1=%0d want 0 0 0",
                     d0_level, d0_busy, d1_level);
        end
    endtask

    initial begin
        test_reset();
        test_message1();
        test_glitch();
        test_restart();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule : tb_i2c_monitor_fifo
`default_nettype wire
